nec_ir_rx: RTL

NEC infrared remote-control receiver/decoder. It takes the demodulated output of an IR receiver module and measures burst and space durations on a 10 µs tick. It decodes the NEC leader, 32-bit data frame and repeat code, and presents the 16-bit address and 8-bit command with single-cycle strobes. It is the receive-side counterpart of the IR carrier/PWM transmit path and sits between the board's IR receiver pin and the command-handling logic.

---
 rtl/nec_ir_rx_if.sv | 12 +
 rtl/nec_ir_rx.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/nec_ir_rx_if.sv
// Decoded-frame output bundle of the NEC IR receiver: latched address/command
// plus the three one-cycle event strobes.
interface nec_ir_rx_if;
  logic [15:0] addr;
  logic [7:0]  cmd;
  logic        valid;
  logic        rpt;
  logic        err;

  modport master (output addr, cmd, valid, rpt, err);
  modport slave  (input  addr, cmd, valid, rpt, err);
endinterface

// File: rtl/nec_ir_rx.sv
// NEC infrared receiver: synchronises the demodulated IR line, times bursts and
// spaces on a 10 us tick, decodes leader/data/repeat and latches address/command.
module nec_ir_rx #(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter bit          INV_IN   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        ir_in,
  nec_ir_rx_if.master rx
);

  localparam int unsigned DIV     = CLK_FREQ / 100_000;
  localparam int unsigned PW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [10:0] CNT_MAX = 11'd1200;

  localparam logic [10:0] LEAD_B_LO = 11'd800;
  localparam logic [10:0] LEAD_B_HI = 11'd1000;
  localparam logic [10:0] LEAD_S_LO = 11'd400;
  localparam logic [10:0] LEAD_S_HI = 11'd500;
  localparam logic [10:0] REP_S_LO  = 11'd200;
  localparam logic [10:0] REP_S_HI  = 11'd250;
  localparam logic [10:0] SHORT_LO  = 11'd40;
  localparam logic [10:0] SHORT_HI  = 11'd70;
  localparam logic [10:0] LONG_LO   = 11'd140;
  localparam logic [10:0] LONG_HI   = 11'd190;

  typedef enum logic [2:0] {
    IDLE,
    LEAD_BURST,
    LEAD_SPACE,
    BIT_BURST,
    BIT_SPACE,
    REP_STOP
  } state_t;

  function automatic logic in_win(input logic [10:0] v,
                                  input logic [10:0] lo,
                                  input logic [10:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // Synchroniser, then a registered edge pulse aligned with the new level in s3
  logic s1, s2, s3, edge_q;
  logic burst;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= INV_IN;
      s2     <= INV_IN;
      s3     <= INV_IN;
      edge_q <= 1'b0;
    end else begin
      s1     <= ir_in;
      s2     <= s1;
      s3     <= s2;
      edge_q <= s2 ^ s3;
    end
  end

  assign burst = s3 ^ INV_IN;

  // meas includes the tick landing in the current cycle so an edge sees floor(duration/tick)
  logic [PW-1:0] pre;
  logic          tick;
  logic [10:0]   cnt;
  logic [10:0]   meas;

  assign tick = (pre == PW'(DIV - 1));
  assign meas = (cnt == CNT_MAX) ? CNT_MAX : cnt + {10'd0, tick};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
      cnt <= '0;
    end else if (edge_q) begin
      pre <= '0;
      cnt <= '0;
    end else begin
      pre <= tick ? '0 : pre + 1'b1;
      cnt <= meas;
    end
  end

  state_t      state, state_n;
  logic [31:0] sh, sh_n;
  logic [5:0]  idx, idx_n;
  logic [15:0] addr_q, addr_n;
  logic [7:0]  cmd_q, cmd_n;
  logic        have_frame, hf_n;
  logic        valid_q, valid_n;
  logic        rpt_q, rpt_n;
  logic        err_q, err_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sh         <= '0;
      idx        <= '0;
      addr_q     <= '0;
      cmd_q      <= '0;
      have_frame <= 1'b0;
      valid_q    <= 1'b0;
      rpt_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state      <= state_n;
      sh         <= sh_n;
      idx        <= idx_n;
      addr_q     <= addr_n;
      cmd_q      <= cmd_n;
      have_frame <= hf_n;
      valid_q    <= valid_n;
      rpt_q      <= rpt_n;
      err_q      <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    sh_n    = sh;
    idx_n   = idx;
    addr_n  = addr_q;
    cmd_n   = cmd_q;
    hf_n    = have_frame;
    valid_n = 1'b0;
    rpt_n   = 1'b0;
    err_n   = 1'b0;

    if (!en) begin
      state_n = IDLE;
    end else if (edge_q) begin
      case (state)
        IDLE: begin
          if (burst) state_n = LEAD_BURST;
        end
        LEAD_BURST: begin
          if (!burst) state_n = in_win(meas, LEAD_B_LO, LEAD_B_HI) ? LEAD_SPACE : IDLE;
        end
        LEAD_SPACE: begin
          if (burst) begin
            if (in_win(meas, LEAD_S_LO, LEAD_S_HI)) begin
              state_n = BIT_BURST;
              idx_n   = '0;
            end else if (in_win(meas, REP_S_LO, REP_S_HI)) begin
              state_n = REP_STOP;
            end else begin
              state_n = IDLE;
              err_n   = 1'b1;
            end
          end
        end
        BIT_BURST: begin
          if (!burst) begin
            if (!in_win(meas, SHORT_LO, SHORT_HI)) begin
              state_n = IDLE;
              err_n   = 1'b1;
            end else if (idx == 6'd32) begin
              state_n = IDLE;
              if (sh[31:24] == ~sh[23:16]) begin
                addr_n  = sh[15:0];
                cmd_n   = sh[23:16];
                hf_n    = 1'b1;
                valid_n = 1'b1;
              end else begin
                err_n = 1'b1;
              end
            end else begin
              state_n = BIT_SPACE;
            end
          end
        end
        BIT_SPACE: begin
          if (burst) begin
            if (in_win(meas, SHORT_LO, SHORT_HI)) begin
              sh_n    = {1'b0, sh[31:1]};
              idx_n   = idx + 6'd1;
              state_n = BIT_BURST;
            end else if (in_win(meas, LONG_LO, LONG_HI)) begin
              sh_n    = {1'b1, sh[31:1]};
              idx_n   = idx + 6'd1;
              state_n = BIT_BURST;
            end else begin
              state_n = IDLE;
              err_n   = 1'b1;
            end
          end
        end
        REP_STOP: begin
          if (!burst) begin
            state_n = IDLE;
            if (!in_win(meas, SHORT_LO, SHORT_HI)) err_n = 1'b1;
            else if (have_frame)                   rpt_n = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end else if ((state != IDLE) && (meas == CNT_MAX)) begin
      // A stuck-on leader is treated as noise; any later stall is a broken frame
      state_n = IDLE;
      err_n   = (state != LEAD_BURST);
    end
  end

  assign rx.addr  = addr_q;
  assign rx.cmd   = cmd_q;
  assign rx.valid = valid_q;
  assign rx.rpt   = rpt_q;
  assign rx.err   = err_q;

endmodule
